aes_key_schedule_iter: RTL and testbench

AES_KEY_SCHEDULE_ITER -- requirements
Module: aes_key_schedule_iter

---
 rtl/aes_pkg.sv | 38 +++
 rtl/aes_sub_word.sv | 13 +
 rtl/aes_key_schedule_iter.sv | 166 ++++++++++++++++
 tb/tb_aes_key_schedule_iter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants: S-box, key length encoding, Nk/Nr lookups, xtime
package aes_pkg;

  typedef enum logic [1:0] {
    KEY_128 = 2'd0,
    KEY_192 = 2'd1,
    KEY_256 = 2'd2,
    KEY_INV = 2'd3
  } key_len_e;

  // Indexed by key_len_e; zero marks the invalid encoding.
  localparam logic [3:0] NK_LUT [4] = '{4'd4, 4'd6, 4'd8, 4'd0};
  localparam logic [3:0] NR_LUT [4] = '{4'd10, 4'd12, 4'd14, 4'd0};

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// rtl/aes_sub_word.sv - four parallel combinational S-box lookups on a 32-bit word
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign sub[8*b +: 8] = SBOX[word[8*b +: 8]];
  end

endmodule

// File: rtl/aes_key_schedule_iter.sv
// rtl/aes_key_schedule_iter.sv - iterative AES key expansion, one word per cycle, round-key read port
module aes_key_schedule_iter
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256,
  parameter bit RK_REG_OUT   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [1:0]              key_len_i,
  input  logic [MAX_KEY_BITS-1:0] key_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    keys_valid_o,
  output logic [3:0]              nr_o,
  input  logic [3:0]              rk_idx_i,
  output logic [127:0]            rk_data_o
);

  localparam int NK_MAX = MAX_KEY_BITS / 32;
  localparam int WORDS  = 4 * (NK_MAX + 7);

  typedef enum logic {IDLE, EXPAND} state_e;

  state_e      state, next_state;
  logic [31:0] w_mem [WORDS];
  logic [5:0]  idx, last_idx;
  logic [3:0]  nk, cnt, nr_run, nr_q;
  logic [7:0]  rcon;
  logic        keys_valid, done_q, err_q;

  key_len_e    len;
  logic [3:0]  nk_in, nr_in;
  logic        len_ok, start_ok, start_bad, last_write, cnt_zero, sub_only;
  logic [31:0] prev, far, sub_in, sub_out, temp;

  assign len    = key_len_e'(key_len_i);
  assign nk_in  = NK_LUT[len];
  assign nr_in  = NR_LUT[len];
  assign len_ok = (len != KEY_INV) && (nk_in <= 4'(NK_MAX));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    last_write = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (len_ok) begin
            start_ok   = 1'b1;
            next_state = EXPAND;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      EXPAND: begin
        if (idx == last_idx) begin
          last_write = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // cnt tracks i mod Nk so the round-constant step needs no divider.
  assign cnt_zero = (cnt == 4'd0);
  assign sub_only = (nk == 4'd8) && (cnt == 4'd4);
  assign prev     = w_mem[idx - 6'd1];
  assign far      = w_mem[idx - {2'b00, nk}];
  assign sub_in   = cnt_zero ? {prev[23:0], prev[31:24]} : prev;
  assign temp     = cnt_zero ? (sub_out ^ {rcon, 24'h0}) : (sub_only ? sub_out : prev);

  aes_sub_word u_sub_word (
    .word (sub_in),
    .sub  (sub_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx        <= '0;
      last_idx   <= '0;
      nk         <= '0;
      cnt        <= '0;
      nr_run     <= '0;
      rcon       <= '0;
      nr_q       <= '0;
      keys_valid <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= last_write;
      err_q  <= start_bad;
      if (start_ok) begin
        idx        <= {2'b00, nk_in};
        nk         <= nk_in;
        cnt        <= '0;
        rcon       <= 8'h01;
        nr_run     <= nr_in;
        last_idx   <= {nr_in, 2'b00} + 6'd3;
        keys_valid <= 1'b0;
        nr_q       <= '0;
      end else if (start_bad) begin
        keys_valid <= 1'b0;
        nr_q       <= '0;
      end else if (state == EXPAND) begin
        idx <= idx + 6'd1;
        cnt <= (cnt == nk - 4'd1) ? 4'd0 : cnt + 4'd1;
        if (cnt_zero) rcon <= xtime(rcon);
        if (last_write) begin
          keys_valid <= 1'b1;
          nr_q       <= nr_run;
        end
      end
    end
  end

  // Word store carries no reset; keys_valid gates every read.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (start_ok) begin
        for (int j = 0; j < NK_MAX; j++) begin
          if (4'(j) < nk_in) w_mem[6'(j)] <= key_i[MAX_KEY_BITS-1-32*j -: 32];
        end
      end else if (state == EXPAND) begin
        w_mem[idx] <= far ^ temp;
      end
    end
  end

  logic         rk_ok;
  logic [5:0]   base;
  logic [127:0] rk_comb;

  assign rk_ok   = keys_valid && (rk_idx_i <= nr_q);
  assign base    = rk_ok ? {rk_idx_i, 2'b00} : 6'd0;
  assign rk_comb = rk_ok ? {w_mem[base], w_mem[base + 6'd1], w_mem[base + 6'd2], w_mem[base + 6'd3]}
                         : 128'h0;

  if (RK_REG_OUT) begin : g_rk_reg
    logic [127:0] rk_q;
    always_ff @(posedge clk) begin
      if (!rst_n) rk_q <= '0;
      else        rk_q <= rk_comb;
    end
    assign rk_data_o = rk_q;
  end else begin : g_rk_comb
    assign rk_data_o = rk_comb;
  end

  assign busy_o       = (state == EXPAND);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign keys_valid_o = keys_valid;
  assign nr_o         = nr_q;

endmodule

// File: tb/tb_aes_key_schedule_iter.sv
// tb/tb_aes_key_schedule_iter.sv - scoreboard bench for aes_key_schedule_iter against a GF(2^8) key expansion model
module tb_aes_key_schedule_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [1:0]   key_len_i;
  logic [255:0] key_i;
  logic         busy_o, done_o, err_o, keys_valid_o;
  logic [3:0]   nr_o;
  logic [3:0]   rk_idx_i;
  logic [127:0] rk_data_o;

  aes_key_schedule_iter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .key_len_i    (key_len_i),
    .key_i        (key_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .keys_valid_o (keys_valid_o),
    .nr_o         (nr_o),
    .rk_idx_i     (rk_idx_i),
    .rk_data_o    (rk_data_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  typedef struct {
    bit         is_done;
    int         due;
    logic [3:0] nr;
  } ev_t;

  typedef struct {
    int           due;
    int           idx;
    logic [127:0] exp;
  } rd_t;

  ev_t ev_q[$];
  rd_t rd_q[$];

  // Reference model: S-box derived from field inversion plus affine map.
  logic [7:0]  sb [256];
  logic [31:0] mw [60];
  int          mnr;
  bit          mkv;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic void expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    for (int i = 0; i < 60; i++) mw[i] = 32'h0;
    for (int i = 0; i < nk; i++) mw[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int j = 1; j < i / nk; j++) rc = gmul(rc, 8'h02);
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endfunction

  ev_t me;
  rd_t mr;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done_o || err_o) begin
        chk("event_expected", 128'(ev_q.size() != 0), 128'd1);
        if (ev_q.size() != 0) begin
          me = ev_q.pop_front();
          chk("done_flag", 128'(done_o), 128'(me.is_done));
          chk("err_flag", 128'(err_o), 128'(!me.is_done));
          chk("event_cycle", 128'(cyc), 128'(me.due));
          chk("nr_o", 128'(nr_o), 128'(me.nr));
          chk("keys_valid_at_event", 128'(keys_valid_o), 128'(me.is_done));
          chk("busy_at_event", 128'(busy_o), 128'd0);
        end
      end
      while (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
        mr = rd_q.pop_front();
        chk($sformatf("rk_data[%0d]", mr.idx), rk_data_o, mr.exp);
      end
    end
  end

  task automatic wait_events();
    int t;
    t = 0;
    while ((ev_q.size() != 0 || rd_q.size() != 0) && t < 300) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    chk("pending_events", 128'(ev_q.size() + rd_q.size()), 128'd0);
    ev_q.delete();
    rd_q.delete();
  endtask

  task automatic start_run(input int len, input logic [255:0] key);
    ev_t e;
    int  nk;
    @(posedge clk); #1;
    start_i   = 1'b1;
    key_len_i = 2'(len);
    key_i     = key;
    if (len < 3) begin
      nk = 4 + 2*len;
      expand(key, nk);
      mnr = nk + 6;
      mkv = 1'b1;
      e.is_done = 1'b1;
      e.due     = cyc + 1 + (4*(mnr+1) - nk);
      e.nr      = 4'(mnr);
    end else begin
      mkv = 1'b0;
      e.is_done = 1'b0;
      e.due     = cyc + 1;
      e.nr      = 4'd0;
    end
    ev_q.push_back(e);
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("busy_after_start", 128'(busy_o), 128'(len < 3));
    chk("kv_after_start", 128'(keys_valid_o), 128'd0);
  endtask

  task automatic read_all(input int kat_idx, input logic [127:0] kat);
    rd_t r;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      rk_idx_i = 4'(i);
      r.due = cyc + 1;
      r.idx = i;
      if (mkv && i <= mnr) r.exp = {mw[4*i], mw[4*i+1], mw[4*i+2], mw[4*i+3]};
      else                 r.exp = 128'h0;
      if (i == kat_idx) r.exp = kat;
      rd_q.push_back(r);
    end
    wait_events();
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  localparam logic [127:0] K128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK128  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK192  = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] RK256  = 128'hfe4890d1e6188d0b046df344706c631e;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int len;
    build_sbox();
    rst_n = 1'b0; start_i = 1'b0; key_len_i = 2'd0; key_i = '0; rk_idx_i = 4'd0;
    mkv = 1'b0; mnr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 128'(busy_o), 128'd0);
    chk("reset_done", 128'(done_o), 128'd0);
    chk("reset_err", 128'(err_o), 128'd0);
    chk("reset_kv", 128'(keys_valid_o), 128'd0);
    chk("reset_nr", 128'(nr_o), 128'd0);
    chk("reset_rk", rk_data_o, 128'h0);
    rst_n = 1'b1;

    // AES-128 with a start pulse mid-run that must be ignored
    start_run(0, {K128, 128'h0});
    repeat (10) @(posedge clk);
    #1;
    start_i = 1'b1; key_len_i = 2'd2; key_i = rand_key();
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("busy_after_ignored_start", 128'(busy_o), 128'd1);
    wait_events();
    read_all(10, RK128);

    // AES-192 started while the previous schedule is valid
    start_run(1, {K192, 64'h0});
    wait_events();
    read_all(12, RK192);

    start_run(2, K256);
    wait_events();
    read_all(14, RK256);

    start_run(3, rand_key());
    wait_events();
    chk("busy_after_err", 128'(busy_o), 128'd0);
    read_all(-1, 128'h0);

    // Reset at cycle 20 of an AES-256 run, then a clean AES-128 run
    start_run(2, rand_key());
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    ev_q.delete();
    mkv = 1'b0;
    @(posedge clk); #1;
    chk("midrun_reset_busy", 128'(busy_o), 128'd0);
    chk("midrun_reset_kv", 128'(keys_valid_o), 128'd0);
    chk("midrun_reset_nr", 128'(nr_o), 128'd0);
    chk("midrun_reset_rk", rk_data_o, 128'h0);
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("kv_after_abort", 128'(keys_valid_o), 128'd0);
    start_run(0, {K128, 128'h0});
    wait_events();
    read_all(10, RK128);

    for (int n = 0; n < 6; n++) begin
      len = $urandom_range(0, 3);
      start_run(len, rand_key());
      wait_events();
      read_all(-1, 128'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
